// File: rtl/cdc_pulse_sync_mc.sv
// Multi-channel pulse synchronizer: two-phase req/ack toggle handshake per channel
// with a saturating pending counter absorbing source-side bursts.
module cdc_pulse_sync_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                    s_clk,
    input  logic                    s_arst_n,
    input  logic                    d_clk,
    input  logic                    d_arst_n,
    input  logic [NUM_CH-1:0]       s_pulse_in,
    input  logic [NUM_CH-1:0]       s_ovf_clr,
    output logic [NUM_CH-1:0]       s_busy,
    output logic [NUM_CH*CNT_W-1:0] s_pending,
    output logic [NUM_CH-1:0]       s_overflow,
    output logic [NUM_CH-1:0]       d_pulse_out
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    // Source domain state
    logic [NUM_CH-1:0] s_req_t;
    logic [NUM_CH-1:0] s_req_t_d;
    logic [NUM_CH-1:0] s_ack_sync;
    logic [NUM_CH-1:0] launch;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] ovf_d;
    logic [CNT_W-1:0]  pend_q [NUM_CH];
    logic [CNT_W-1:0]  pend_d [NUM_CH];

    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] s_ack_sync_q [STAGES];

    // Destination domain state
    logic [NUM_CH-1:0] d_req;
    logic [NUM_CH-1:0] d_req_q;
    logic [NUM_CH-1:0] d_ack_t;

    (* ASYNC_REG = "TRUE" *) logic [NUM_CH-1:0] d_req_sync_q [STAGES];

    assign s_ack_sync = s_ack_sync_q[STAGES-1];
    assign s_busy     = s_req_t ^ s_ack_sync;

    always_comb begin
        launch = '0;
        drop   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pend_d[ch] = pend_q[ch];
            launch[ch] = !s_busy[ch] && ((pend_q[ch] != '0) || s_pulse_in[ch]);
            drop[ch]   = s_pulse_in[ch] && !launch[ch] && (pend_q[ch] == PEND_MAX);
            // A pulse and a launch in the same cycle cancel out; a dropped pulse holds.
            if (!drop[ch] && (s_pulse_in[ch] != launch[ch])) begin
                if (s_pulse_in[ch]) begin
                    pend_d[ch] = pend_q[ch] + 1'b1;
                end else begin
                    pend_d[ch] = pend_q[ch] - 1'b1;
                end
            end
        end
        s_req_t_d = s_req_t ^ launch;
        ovf_d     = drop | (s_overflow & ~s_ovf_clr);
    end

    always_comb begin
        s_pending = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            s_pending[ch*CNT_W +: CNT_W] = pend_q[ch];
        end
    end

    always_ff @(posedge s_clk or negedge s_arst_n) begin
        if (!s_arst_n) begin
            s_req_t    <= '0;
            s_overflow <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pend_q[ch] <= '0;
            end
            for (int i = 0; i < STAGES; i++) begin
                s_ack_sync_q[i] <= '0;
            end
        end else begin
            s_req_t    <= s_req_t_d;
            s_overflow <= ovf_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pend_q[ch] <= pend_d[ch];
            end
            s_ack_sync_q[0] <= d_ack_t;
            for (int i = 1; i < STAGES; i++) begin
                s_ack_sync_q[i] <= s_ack_sync_q[i-1];
            end
        end
    end

    assign d_req       = d_req_sync_q[STAGES-1];
    assign d_pulse_out = d_req ^ d_req_q;

    always_ff @(posedge d_clk or negedge d_arst_n) begin
        if (!d_arst_n) begin
            d_req_q <= '0;
            d_ack_t <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_req_sync_q[i] <= '0;
            end
        end else begin
            d_req_q         <= d_req;
            d_ack_t         <= d_req;
            d_req_sync_q[0] <= s_req_t;
            for (int i = 1; i < STAGES; i++) begin
                d_req_sync_q[i] <= d_req_sync_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_cdc_pulse_sync_mc.sv
// Randomized scoreboard bench: source driver predicts launches and counter state,
// a destination monitor pops expected deliveries and checks width and latency.
`timescale 1ns/1ps
module tb_cdc_pulse_sync_mc;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned STAGES = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PMAX   = (1 << CNT_W) - 1;

    logic                    s_clk = 1'b0;
    logic                    d_clk = 1'b0;
    logic                    s_arst_n;
    logic                    d_arst_n;
    logic [NUM_CH-1:0]       s_pulse_in;
    logic [NUM_CH-1:0]       s_ovf_clr;
    logic [NUM_CH-1:0]       s_busy;
    logic [NUM_CH*CNT_W-1:0] s_pending;
    logic [NUM_CH-1:0]       s_overflow;
    logic [NUM_CH-1:0]       d_pulse_out;

    int      checks   = 0;
    int      failures = 0;
    realtime s_half   = 5.0;
    realtime d_half   = 13.5;

    // Reference model: queued pulse count, sticky flag, and launch timestamps per channel.
    realtime           lq [NUM_CH][$];
    int unsigned       m_pend [NUM_CH];
    logic [NUM_CH-1:0] m_ovf;
    logic [NUM_CH-1:0] m_launched;
    int                accepted [NUM_CH];
    int                delivered [NUM_CH];
    logic [NUM_CH-1:0] prev_d;

    cdc_pulse_sync_mc #(
        .NUM_CH (NUM_CH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .s_clk       (s_clk),
        .s_arst_n    (s_arst_n),
        .d_clk       (d_clk),
        .d_arst_n    (d_arst_n),
        .s_pulse_in  (s_pulse_in),
        .s_ovf_clr   (s_ovf_clr),
        .s_busy      (s_busy),
        .s_pending   (s_pending),
        .s_overflow  (s_overflow),
        .d_pulse_out (d_pulse_out)
    );

    always #(s_half) s_clk = ~s_clk;
    always #(d_half) d_clk = ~d_clk;

    task automatic check(input string name, input int ch, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s ch%0d: got %0d expected %0d at %0t", name, ch, act, exp, $realtime);
        end
    endtask

    function automatic int pend_of(input int ch);
        return int'(s_pending[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic clear_model();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_pend[ch]    = 0;
            accepted[ch]  = 0;
            delivered[ch] = 0;
            lq[ch].delete();
        end
        m_ovf      = '0;
        m_launched = '0;
    endtask

    // Called at a falling s_clk edge; DUT state must equal the model state.
    task automatic cycle(input logic [NUM_CH-1:0] p, input logic [NUM_CH-1:0] c);
        bit launch;
        bit drop;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check("pending", ch, pend_of(ch), int'(m_pend[ch]));
            check("overflow", ch, int'(s_overflow[ch]), int'(m_ovf[ch]));
            if (m_launched[ch]) check("busy_after_launch", ch, int'(s_busy[ch]), 1);
        end
        s_pulse_in = p;
        s_ovf_clr  = c;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            launch = !s_busy[ch] && (m_pend[ch] != 0 || p[ch]);
            drop   = p[ch] && !launch && (m_pend[ch] == PMAX);
            if (launch) lq[ch].push_back($realtime);
            if (p[ch] && !drop) accepted[ch]++;
            if (!drop) m_pend[ch] = m_pend[ch] + (p[ch] ? 1 : 0) - (launch ? 1 : 0);
            m_ovf[ch]      = drop || (m_ovf[ch] && !c[ch]);
            m_launched[ch] = launch;
        end
        @(negedge s_clk);
    endtask

    function automatic bit work_left();
        bit any = (s_busy != '0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (lq[ch].size() != 0 || m_pend[ch] != 0) any = 1'b1;
        end
        return any;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (work_left() && n < budget) begin
            cycle('0, '0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout: still busy after %0d cycles (required idle)", n);
        end
        repeat (4) cycle('0, '0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check("delivered_vs_accepted", ch, delivered[ch], accepted[ch]);
        end
    endtask

    task automatic rand_phase(input int n);
        logic [NUM_CH-1:0] p;
        logic [NUM_CH-1:0] c;
        clear_model_counts();
        cycle('1, '0);
        for (int k = 1; k < n; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                p[ch] = ($urandom_range(0, 3) == 0);
                c[ch] = ($urandom_range(0, 31) == 0);
            end
            cycle(p, c);
        end
        drain(8000);
    endtask

    task automatic clear_model_counts();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            accepted[ch]  = 0;
            delivered[ch] = 0;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 0, int'(s_busy), 0);
        check({name, "_pending"}, 0, int'(s_pending), 0);
        check({name, "_overflow"}, 0, int'(s_overflow), 0);
        check({name, "_d_pulse"}, 0, int'(d_pulse_out), 0);
    endtask

    // Destination monitor: each pulse must match a queued launch, be one cycle wide,
    // and arrive within the synchronizer latency.
    always @(negedge d_clk) begin
        if (!d_arst_n) begin
            prev_d = '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (d_pulse_out[ch]) begin
                    realtime lim;
                    realtime t0;
                    check("pulse_width", ch, int'(prev_d[ch]), 0);
                    checks++;
                    if (lq[ch].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse ch%0d: got pulse, expected none queued", ch);
                    end else begin
                        t0  = lq[ch].pop_front();
                        lim = 2.0 * s_half + real'(STAGES + 1) * 2.0 * d_half + d_half + 1.0;
                        delivered[ch]++;
                        checks++;
                        if ($realtime - t0 > lim) begin
                            failures++;
                            $display("FAIL latency ch%0d: got %0t expected <= %0t",
                                     ch, $realtime - t0, lim);
                        end
                    end
                end
            end
            prev_d = d_pulse_out;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        s_arst_n   = 1'b0;
        d_arst_n   = 1'b0;
        s_pulse_in = '0;
        s_ovf_clr  = '0;
        prev_d     = '0;
        clear_model();
        repeat (3) @(negedge s_clk);
        check_all_zero("reset");
        s_arst_n = 1'b1;
        d_arst_n = 1'b1;
        @(negedge s_clk);

        // Single pulse, d_clk at 37 MHz
        cycle(4'b0001, '0);
        drain(2000);
        check("single_delivered", 0, delivered[0], 1);

        // Burst of five on ch1: one launches, four queue
        clear_model_counts();
        repeat (5) cycle(4'b0010, '0);
        check("burst_peak", 1, pend_of(1), 4);
        drain(2000);
        check("burst_delivered", 1, delivered[1], 5);

        // Overflow on ch2 with a much slower d_clk
        d_half = 100.0;
        @(negedge s_clk);
        clear_model_counts();
        repeat (20) cycle(4'b0100, '0);
        check("ovf_pend_full", 2, pend_of(2), int'(PMAX));
        check("ovf_set", 2, int'(s_overflow[2]), 1);
        cycle('0, 4'b0100);
        check("ovf_cleared", 2, int'(s_overflow[2]), 0);
        cycle(4'b0100, 4'b0100);
        check("ovf_set_wins", 2, int'(s_overflow[2]), 1);
        drain(8000);
        check("ovf_delivered", 2, delivered[2], int'(PMAX) + 1);
        cycle('0, '1);

        // Reset both domains mid-transfer with three queued
        d_half = 13.5;
        @(negedge s_clk);
        clear_model_counts();
        repeat (4) cycle(4'b0001, '0);
        check("pre_reset_pend", 0, pend_of(0), 3);
        s_pulse_in = '0;
        s_arst_n   = 1'b0;
        d_arst_n   = 1'b0;
        #1;
        check_all_zero("midreset");
        clear_model();
        repeat (3) @(negedge s_clk);
        s_arst_n = 1'b1;
        d_arst_n = 1'b1;
        @(negedge s_clk);
        cycle(4'b0001, '0);
        drain(2000);
        check("post_reset_delivered", 0, delivered[0], 1);

        // Random traffic at three clock ratios
        rand_phase(1000);
        d_half = 1.25;
        @(negedge s_clk);
        rand_phase(1000);
        d_half = 20.0;
        @(negedge s_clk);
        rand_phase(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_pulse_sync_mc.md
Name: cdc_pulse_sync_mc

Overview:
Multi-channel pulse synchronizer built on a two-phase (toggle) req/ack handshake. It moves 1-cycle pulses from the s_clk domain to the d_clk domain with no loss and no duplication. Each channel has a saturating pending counter, so the source may pulse at any time, including while a transfer is in flight. It is used for event and interrupt forwarding between unrelated clock domains.

Parameters:
NUM_CH, 4, number of independent pulse channels (1..32).
STAGES, 2, synchronizer depth in each direction (2 or 3); flops carry ASYNC_REG.
CNT_W, 4, width of the per-channel pending counter; maximum queued pulses = 2^CNT_W-1.

Ports:
s_clk  in  1  source clock.
s_arst_n  in  1  source reset, asynchronous, active-low.
d_clk  in  1  destination clock.
d_arst_n  in  1  destination reset, asynchronous, active-low.
s_pulse_in  in  NUM_CH  per-channel 1-cycle event, s_clk domain.
s_ovf_clr  in  NUM_CH  per-channel clear of the sticky overflow flag.
s_busy  out  NUM_CH  transfer in flight (s_req_t ^ s_ack_sync).
s_pending  out  NUM_CH*CNT_W  per-channel queued count; channel i occupies bits [i*CNT_W +: CNT_W].
s_overflow  out  NUM_CH  sticky flag: a pulse was dropped because the counter was full.
d_pulse_out  out  NUM_CH  per-channel 1-cycle pulse, d_clk domain.

Behaviour:
- Reset: s_arst_n, asynchronous, active-low; clock s_clk.
- s_arst_n low clears s_req_t, the ack sync chain, pend and s_overflow. Result: s_busy=0, s_pending=0, s_overflow=0.
- d_arst_n low clears the req sync chain, d_req_q and d_ack_t. Result: d_pulse_out=0.
- Both resets are asserted together. Reset of one domain alone while a transfer is in flight is unsupported; it may lose or duplicate one pulse.
- Per channel, source side:
  - launch = !s_busy & (pend!=0 | s_pulse_in).
  - On launch, s_req_t toggles on the next s_clk edge.
  - pend_next = pend + s_pulse_in - launch, with saturation at 2^CNT_W-1.
  - Pulse arriving while idle with pend==0: launches directly; pend stays 0.
  - s_pulse_in and launch in the same cycle with pend>0: pend is unchanged.
  - pend at max, s_pulse_in=1 and no launch: the pulse is dropped, pend holds, s_overflow sets next cycle.
  - Overflow set and s_ovf_clr in the same cycle: set wins.
- Destination side:
  - s_req_t passes through an STAGES-flop chain to d_req.
  - d_req_q <= d_req.
  - d_pulse_out = d_req ^ d_req_q: exactly one d_clk cycle per toggle.
  - d_ack_t <= d_req.
- Ack return: d_ack_t passes through an STAGES-flop chain in s_clk to s_ack_sync. s_busy falls when s_ack_sync equals s_req_t.
- Latency:
  - d_pulse_out rises STAGES to STAGES+1 d_clk edges after the s_req_t toggle.
  - Round trip, i.e. minimum spacing between launches on one channel: about STAGES+1 d_clk plus STAGES+1 s_clk cycles.
  - Throughput per channel is one pulse per round trip. The counter absorbs bursts.
- Two-phase protocol: there is no return-to-zero phase, so each transfer costs one round trip, not two.
- Channels are fully independent. No cross-channel ordering is guaranteed.
- Clock ratio: either clock may be faster, in any ratio. Correctness never depends on the ratio.
- All outputs are registered or come from a single XOR of flops. No combinational path crosses a domain.

Test Plan:
- Single pulse, ch0, s_clk 100 MHz, d_clk 37 MHz → exactly 1 d_pulse_out[0] within 4 d_clk edges of the toggle. s_busy[0] then returns to 0; s_pending[0] stays 0.
- Burst of 5 back-to-back s_pulse_in[1] cycles, CNT_W=4 → s_pending[1] peaks at 4. Exactly 5 d_pulse_out[1] pulses follow, each separated by at least one round trip, and s_pending[1] ends at 0.
- CNT_W=2, 6 consecutive pulses while d_clk is 10x slower → 4 are delivered: 1 launched plus 3 queued. s_overflow sets after the 5th pulse. An s_ovf_clr pulse clears it; an overflow event in the same cycle as a clear keeps it set.
- All NUM_CH channels pulsed simultaneously, plus random pulses, 1000 cycles → per-channel delivered count equals sent count minus overflow drops. No channel affects another.
- d_clk 4x faster than s_clk, and then 4x slower → same counts as above. d_pulse_out is never wider than 1 d_clk cycle.
- Both resets asserted mid-transfer with s_pending=3 → all outputs read 0 next cycle. A fresh pulse after release is delivered exactly once.
